// File: rtl/cosx_sched_pkg.sv
// Shared types and widths for the cosx round-robin scheduler.
package cosx_sched_pkg;

    localparam int unsigned X_W         = 16;
    localparam int unsigned Y_W         = 8;
    localparam int unsigned T_W         = 16;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } operand_t;

endpackage

// File: rtl/cosx_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_REQ.
module cosx_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    logic [ID_W-1:0] j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = ID_W'((32'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/cosx_rr_scheduler.sv
// Shares one cosx engine among N_REQ requesters, one job in flight.
// Optional engine watchdog enabled by defining COSX_SCHED_TIMEOUT_EN.
module cosx_rr_scheduler
    import cosx_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2
`ifdef COSX_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [X_W*N_REQ-1:0]   req_x,
    input  logic [Y_W*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]       req_ack,
    output logic                   eng_start,
    output logic [X_W-1:0]         eng_x,
    output logic [Y_W-1:0]         eng_y,
    input  logic                   eng_done,
    input  logic [T_W-1:0]         eng_total,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [T_W-1:0]         resp_data,
    output logic                   resp_err,
    output logic                   busy
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    operand_t        op_q, op_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [T_W-1:0]  data_q, data_d;
    logic            start_q, valid_q, busy_q;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_valid;
    logic [ID_W-1:0]  ptr_next;

    logic [X_W-1:0] x_arr [N_REQ];
    logic [Y_W-1:0] y_arr [N_REQ];

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_slice
        assign x_arr[i] = req_x[X_W*i +: X_W];
        assign y_arr[i] = req_y[Y_W*i +: Y_W];
    end

    cosx_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

`ifdef COSX_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tmo;

    assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        req_ack = '0;
`ifdef COSX_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req_ack = grant;
                    op_d.x  = x_arr[gnt_idx];
                    op_d.y  = y_arr[gnt_idx];
                    id_d    = gnt_idx;
                    ptr_d   = ptr_next;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef COSX_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    data_d  = eng_total;
`ifdef COSX_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef COSX_SCHED_TIMEOUT_EN
                else if (tmo) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            op_q    <= '0;
            id_q    <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            start_q <= (state_d == ISSUE);
            valid_q <= (state_d == RESP);
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef COSX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign eng_start  = start_q;
    assign eng_x      = op_q.x;
    assign eng_y      = op_q.y;
    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;

endmodule
